mem_arbiter: RTL and testbench

- Shares the single physical memory port (pmem DPI bridge) between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle NPC core.
- Provides valid/ready request handshakes on both sides and routes each response back to the requester that issued it.
- Only one transaction is outstanding at a time; arbitration is round-robin.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } arb_state_e;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned MASK_W     = DATA_W_DEF / 8;

  function automatic int unsigned mask_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_valid,       // [REQ_IFU], [REQ_LSU]
  input  logic       i_last_grant,
  output logic       o_grant_valid,
  output logic       o_grant_id
);

  always_comb begin
    o_grant_valid = |i_valid;
    o_grant_id    = REQ_IFU;
    case (i_valid)
      2'b01:   o_grant_id = REQ_IFU;
      2'b10:   o_grant_id = REQ_LSU;
      2'b11:   o_grant_id = ~i_last_grant;
      default: o_grant_id = REQ_IFU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight at a time.
// Optional response watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ifu_req_valid,
  output logic                o_ifu_req_ready,
  input  logic [ADDR_W-1:0]   i_ifu_addr,
  output logic                o_ifu_resp_valid,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  input  logic                i_lsu_req_valid,
  output logic                o_lsu_req_ready,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic                i_lsu_wen,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wmask,
  output logic                o_lsu_resp_valid,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_resp_valid,
  input  logic [DATA_W-1:0]   i_mem_rdata
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                o_mem_timeout
`endif
);

  localparam int unsigned MW = mask_w(DATA_W);

  arb_state_e        r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_wen;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [MW-1:0]     r_mem_wmask;
  logic              r_ifu_resp_valid;
  logic              r_lsu_resp_valid;
  logic [DATA_W-1:0] r_ifu_rdata;
  logic [DATA_W-1:0] r_lsu_rdata;

  logic w_grant_valid;
  logic w_grant_id;
  logic w_idle;
  logic w_ifu_hs;
  logic w_lsu_hs;
  logic w_tmo_fire;

  rr_arbiter2 u_rr_arbiter2 (
    .i_valid       ({i_lsu_req_valid, i_ifu_req_valid}),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_idle   = (r_state == StIdle);
  assign w_ifu_hs = w_idle & w_grant_valid & (w_grant_id == REQ_IFU);
  assign w_lsu_hs = w_idle & w_grant_valid & (w_grant_id == REQ_LSU);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC < 256) ? 8 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_mem_timeout;
  logic             w_tmo;

  assign w_tmo      = (r_tmo_cnt >= CNT_W'(TIMEOUT_CYC - 1));
  // A real response or request acceptance in the same cycle beats the watchdog.
  assign w_tmo_fire = w_tmo & (((r_state == StReq) & ~i_mem_req_ready) |
                               ((r_state == StWait) & ~i_mem_resp_valid));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt     <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_mem_timeout <= w_tmo_fire;
      if (w_ifu_hs || w_lsu_hs) begin
        r_tmo_cnt <= '0;
      end else if (((r_state == StReq) || (r_state == StWait)) && (r_tmo_cnt != '1)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign o_mem_timeout = r_mem_timeout;
`else
  assign w_tmo_fire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= StIdle;
      r_last_grant     <= REQ_LSU;
      r_owner          <= REQ_IFU;
      r_mem_req_valid  <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wen        <= 1'b0;
      r_mem_wdata      <= '0;
      r_mem_wmask      <= '0;
      r_ifu_resp_valid <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      r_ifu_rdata      <= '0;
      r_lsu_rdata      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_ifu_hs || w_lsu_hs) begin
            r_state         <= StReq;
            r_mem_req_valid <= 1'b1;
            r_owner         <= w_grant_id;
            r_last_grant    <= w_grant_id;
            if (w_lsu_hs) begin
              r_mem_addr  <= i_lsu_addr;
              r_mem_wen   <= i_lsu_wen;
              r_mem_wdata <= i_lsu_wdata;
              r_mem_wmask <= i_lsu_wmask;
            end else begin
              r_mem_addr  <= i_ifu_addr;
              r_mem_wen   <= 1'b0;
              r_mem_wdata <= '0;
              r_mem_wmask <= '0;
            end
          end
        end
        StReq: begin
          if (i_mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= StWait;
          end else if (w_tmo_fire) begin
            r_mem_req_valid  <= 1'b0;
            r_state          <= StResp;
            r_ifu_resp_valid <= (r_owner == REQ_IFU);
            r_lsu_resp_valid <= (r_owner == REQ_LSU);
            if (r_owner == REQ_IFU) r_ifu_rdata <= '0;
            else                    r_lsu_rdata <= '0;
          end
        end
        StWait: begin
          if (i_mem_resp_valid || w_tmo_fire) begin
            r_state          <= StResp;
            r_ifu_resp_valid <= (r_owner == REQ_IFU);
            r_lsu_resp_valid <= (r_owner == REQ_LSU);
            if (r_owner == REQ_IFU) r_ifu_rdata <= i_mem_resp_valid ? i_mem_rdata : '0;
            else                    r_lsu_rdata <= i_mem_resp_valid ? i_mem_rdata : '0;
          end
        end
        StResp: begin
          r_ifu_resp_valid <= 1'b0;
          r_lsu_resp_valid <= 1'b0;
          r_state          <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ifu_req_ready  = w_ifu_hs;
  assign o_lsu_req_ready  = w_lsu_hs;
  assign o_ifu_resp_valid = r_ifu_resp_valid;
  assign o_lsu_resp_valid = r_lsu_resp_valid;
  assign o_ifu_rdata      = r_ifu_rdata;
  assign o_lsu_rdata      = r_lsu_rdata;
  assign o_mem_req_valid  = r_mem_req_valid;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_wen        = r_mem_wen;
  assign o_mem_wdata      = r_mem_wdata;
  assign o_mem_wmask      = r_mem_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant table, corner sequences, random scoreboard.
// Also exercises the watchdog when built with MEM_TIMEOUT_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned MW = MASK_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0]   ifu_addr, ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0]   lsu_addr, lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;
`ifdef MEM_TIMEOUT_EN
  logic          mem_timeout;
`endif

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (8)
`endif
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ifu_req_valid  (ifu_req_valid),
    .o_ifu_req_ready  (ifu_req_ready),
    .i_ifu_addr       (ifu_addr),
    .o_ifu_resp_valid (ifu_resp_valid),
    .o_ifu_rdata      (ifu_rdata),
    .i_lsu_req_valid  (lsu_req_valid),
    .o_lsu_req_ready  (lsu_req_ready),
    .i_lsu_addr       (lsu_addr),
    .i_lsu_wen        (lsu_wen),
    .i_lsu_wdata      (lsu_wdata),
    .i_lsu_wmask      (lsu_wmask),
    .o_lsu_resp_valid (lsu_resp_valid),
    .o_lsu_rdata      (lsu_rdata),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_addr       (mem_addr),
    .o_mem_wen        (mem_wen),
    .o_mem_wdata      (mem_wdata),
    .o_mem_wmask      (mem_wmask),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_rdata      (mem_rdata)
`ifdef MEM_TIMEOUT_EN
    ,
    .o_mem_timeout    (mem_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid  = 1'b0;
    ifu_addr       = '0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = '0;
    lsu_wen        = 1'b0;
    lsu_wdata      = '0;
    lsu_wmask      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ifu_ready"}, ifu_req_ready, 0);
    chk({tag, " lsu_ready"}, lsu_req_ready, 0);
    chk({tag, " ifu_resp"}, ifu_resp_valid, 0);
    chk({tag, " lsu_resp"}, lsu_resp_valid, 0);
    chk({tag, " ifu_rdata"}, ifu_rdata, 0);
    chk({tag, " lsu_rdata"}, lsu_rdata, 0);
    chk({tag, " mem_req_valid"}, mem_req_valid, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wen"}, mem_wen, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " mem_wmask"}, mem_wmask, 0);
  endtask

  // ---------------- table-driven grant vectors ----------------
  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic [31:0] ifu_a;
    logic [31:0] lsu_a;
    logic [31:0] rdata;
    logic        win;      // 0 = IFU, 1 = LSU
  } vec_t;

  vec_t vecs[11];

  // One full transaction with immediate memory: ready on cycle 0, resp on cycle 3.
  task automatic run_vec(input vec_t v, input string tag);
    next_cycle();
    ifu_req_valid = v.ifu_v;
    lsu_req_valid = v.lsu_v;
    ifu_addr      = v.ifu_a;
    lsu_addr      = v.lsu_a;
    lsu_wen       = 1'b0;
    lsu_wdata     = $urandom;
    lsu_wmask     = '1;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    #3;
    chk({tag, " ifu_ready"}, ifu_req_ready, v.win == 1'b0);
    chk({tag, " lsu_ready"}, lsu_req_ready, v.win == 1'b1);
    next_cycle();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    #3;
    chk({tag, " mem_req_valid"}, mem_req_valid, 1);
    chk({tag, " mem_addr"}, mem_addr, v.win ? v.lsu_a : v.ifu_a);
    chk({tag, " mem_wen"}, mem_wen, 0);
    next_cycle();
    mem_resp_valid = 1'b1;
    mem_rdata      = v.rdata;
    #3;
    chk({tag, " mem_req_valid_wait"}, mem_req_valid, 0);
    next_cycle();
    mem_resp_valid = 1'b0;
    mem_rdata      = $urandom;
    #3;
    chk({tag, " ifu_resp"}, ifu_resp_valid, v.win == 1'b0);
    chk({tag, " lsu_resp"}, lsu_resp_valid, v.win == 1'b1);
    chk({tag, " rdata"}, v.win ? lsu_rdata : ifu_rdata, v.rdata);
    next_cycle();
    #3;
    chk({tag, " ifu_resp_end"}, ifu_resp_valid, 0);
    chk({tag, " lsu_resp_end"}, lsu_resp_valid, 0);
  endtask

  // ---------------- random scoreboard model ----------------
  logic [31:0] mem_m [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [MW-1:0] m);
    logic [31:0] v;
    v = mem_read(a);
    for (int b = 0; b < int'(MW); b++) begin
      if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    end
    mem_m[a] = v;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic          m_busy, m_pend, m_wait, m_due, m_owner, m_last, m_wen;
    logic          e_ifu_rdy, e_lsu_rdy;
    logic [31:0]   m_addr, m_wdata, m_ifu_rd, m_lsu_rd;
    logic [MW-1:0] m_wmask;
    int            stall;
    int            seen;

    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    #3;
    chk_all_zero("post_reset_idle");

    // Right after reset LSU counts as last granted, so IFU wins the first tie.
    vecs[0]  = '{1'b1, 1'b1, 32'h8000_0100, 32'h8000_2000, 32'h1111_0001, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h8000_0104, 32'h8000_2004, 32'h1111_0002, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 32'h8000_0108, 32'h8000_2008, 32'h1111_0003, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_200C, 32'h0000_0413, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h8000_010C, 32'h8000_2010, 32'h1111_0005, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h8000_0110, 32'h8000_2014, 32'h1111_0006, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'h8000_0114, 32'h8000_2018, 32'h1111_0007, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h8000_0118, 32'h8000_201C, 32'h1111_0008, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h8000_011C, 32'h8000_2020, 32'h1111_0009, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h8000_0120, 32'h8000_2024, 32'h1111_000A, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 32'h8000_0124, 32'h8000_2028, 32'h1111_000B, 1'b0};
    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stray memory responses in IDLE, then a stalled store with strays in REQ.
    next_cycle();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0BAD_0BAD;
    next_cycle();
    #3;
    chk("idle_stray ifu_resp", ifu_resp_valid, 0);
    chk("idle_stray lsu_resp", lsu_resp_valid, 0);
    next_cycle();
    mem_resp_valid = 1'b0;
    lsu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_1000;
    lsu_wen        = 1'b1;
    lsu_wdata      = 32'hDEAD_BEEF;
    lsu_wmask      = 4'b0011;
    mem_req_ready  = 1'b0;
    #3;
    chk("store lsu_ready", lsu_req_ready, 1);
    chk("store idle_stray lsu_resp", lsu_resp_valid, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      lsu_req_valid  = 1'b0;
      lsu_addr       = 32'h0;
      lsu_wdata      = 32'h0;
      lsu_wmask      = 4'b0;
      mem_req_ready  = (k == 3);
      mem_resp_valid = (k != 3);
      #3;
      chk($sformatf("store%0d mem_req_valid", k), mem_req_valid, 1);
      chk($sformatf("store%0d mem_addr", k), mem_addr, 32'h8000_1000);
      chk($sformatf("store%0d mem_wen", k), mem_wen, 1);
      chk($sformatf("store%0d mem_wdata", k), mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("store%0d mem_wmask", k), mem_wmask, 4'b0011);
      chk($sformatf("store%0d lsu_resp", k), lsu_resp_valid, 0);
    end
    next_cycle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hCAFE_0001;
    #3;
    chk("store wait mem_req_valid", mem_req_valid, 0);
    next_cycle();
    mem_resp_valid = 1'b0;
    #3;
    chk("store lsu_resp", lsu_resp_valid, 1);
    chk("store ifu_resp", ifu_resp_valid, 0);
    chk("store lsu_rdata", lsu_rdata, 32'hCAFE_0001);
    next_cycle();
    #3;
    chk("store lsu_resp_once", lsu_resp_valid, 0);
    chk("store lsu_rdata_hold", lsu_rdata, 32'hCAFE_0001);

    // Asynchronous reset while waiting for the memory response.
    next_cycle();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0010;
    mem_req_ready = 1'b1;
    #3;
    chk("rst_seq ifu_ready", ifu_req_ready, 1);
    next_cycle();
    ifu_req_valid = 1'b0;
    next_cycle();
    mem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    next_cycle();
    rst_n = 1'b1;
    run_vec('{1'b1, 1'b1, 32'h8000_0020, 32'h8000_3000, 32'h2222_0001, 1'b0}, "after_reset");

`ifdef MEM_TIMEOUT_EN
    next_cycle();
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0040;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    #3;
    chk("tmo ifu_ready", ifu_req_ready, 1);
    seen = -1;
    for (int k = 1; k <= 20 && seen < 0; k++) begin
      next_cycle();
      ifu_req_valid = 1'b0;
      #3;
      if (mem_timeout) begin
        seen = k;
        chk("tmo ifu_resp", ifu_resp_valid, 1);
        chk("tmo ifu_rdata", ifu_rdata, 0);
        chk("tmo lsu_resp", lsu_resp_valid, 0);
      end
    end
    chk("tmo pulse within window", (seen >= 8) && (seen <= 10), 1);
    next_cycle();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h7777_7777;
    #3;
    chk("tmo pulse once", mem_timeout, 0);
    chk("tmo back_idle mem_req_valid", mem_req_valid, 0);
    chk("tmo late ifu_resp", ifu_resp_valid, 0);
    next_cycle();
    mem_resp_valid = 1'b0;
    #3;
    chk("tmo late ignored", ifu_resp_valid, 0);
    chk("tmo rdata stays", ifu_rdata, 0);
`endif

    // Randomised traffic against a transaction-level scoreboard.
    next_cycle();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n    = 1'b1;
    m_busy   = 1'b0;
    m_pend   = 1'b0;
    m_wait   = 1'b0;
    m_due    = 1'b0;
    m_owner  = 1'b0;
    m_last   = 1'b1;
    m_wen    = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wmask  = '0;
    m_ifu_rd = '0;
    m_lsu_rd = '0;
    stall    = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      next_cycle();
      ifu_req_valid = ($urandom_range(0, 99) < 45);
      ifu_addr      = 32'h8000_0000 + ($urandom_range(0, 7) << 2);
      lsu_req_valid = ($urandom_range(0, 99) < 45);
      lsu_addr      = 32'h8000_0000 + ($urandom_range(0, 7) << 2);
      lsu_wen       = $urandom_range(0, 1);
      lsu_wdata     = $urandom;
      lsu_wmask     = MW'($urandom);
      mem_req_ready = m_pend ? (($urandom_range(0, 1) == 1) || (stall >= 2))
                             : ($urandom_range(0, 1) == 1);
      if (m_wait) begin
        mem_resp_valid = ($urandom_range(0, 1) == 1) || (stall >= 2);
        mem_rdata      = mem_read(m_addr);
      end else begin
        mem_resp_valid = ($urandom_range(0, 9) == 0);
        mem_rdata      = $urandom;
      end
      #3;
      e_ifu_rdy = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last);
      e_lsu_rdy = !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last);
      chk("rnd ifu_ready", ifu_req_ready, e_ifu_rdy);
      chk("rnd lsu_ready", lsu_req_ready, e_lsu_rdy);
      chk("rnd mem_req_valid", mem_req_valid, m_pend);
      if (m_pend) begin
        chk("rnd mem_addr", mem_addr, m_addr);
        chk("rnd mem_wen", mem_wen, m_wen);
        chk("rnd mem_wmask", mem_wmask, m_wmask);
        if (m_owner) chk("rnd mem_wdata", mem_wdata, m_wdata);
      end
      chk("rnd ifu_resp", ifu_resp_valid, m_due && !m_owner);
      chk("rnd lsu_resp", lsu_resp_valid, m_due && m_owner);
      chk("rnd ifu_rdata", ifu_rdata, m_ifu_rd);
      chk("rnd lsu_rdata", lsu_rdata, m_lsu_rd);
      if (m_due) begin
        m_due  = 1'b0;
        m_busy = 1'b0;
      end else if (m_wait) begin
        stall++;
        if (mem_resp_valid) begin
          m_wait = 1'b0;
          m_due  = 1'b1;
          if (m_owner) m_lsu_rd = mem_rdata;
          else         m_ifu_rd = mem_rdata;
          if (m_owner && m_wen) mem_write(m_addr, m_wdata, m_wmask);
        end
      end else if (m_pend) begin
        stall++;
        if (mem_req_ready) begin
          m_pend = 1'b0;
          m_wait = 1'b1;
          stall  = 0;
        end
      end else if (e_ifu_rdy || e_lsu_rdy) begin
        m_busy  = 1'b1;
        m_pend  = 1'b1;
        stall   = 0;
        m_owner = e_lsu_rdy;
        m_last  = e_lsu_rdy;
        m_addr  = e_lsu_rdy ? lsu_addr : ifu_addr;
        m_wen   = e_lsu_rdy ? lsu_wen : 1'b0;
        m_wdata = lsu_wdata;
        m_wmask = e_lsu_rdy ? lsu_wmask : '0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
